mop_queue: RTL

MOP_QUEUE -- requirements
Module: mop_queue

---
 rtl/mop_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mop_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mop_queue                                                            |
// | Circular micro-op queue between decode and register read. Accepts    |
// | 0/1/2 micro-ops per cycle (all-or-nothing), releases one per cycle.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

package mop_queue_pkg;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [5:0]  rd;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [31:0] imm;
  } micro_op_t;

  localparam int MOP_W = $bits(micro_op_t);
endpackage

module mop_queue #(
  parameter int DEPTH = 8  // power of two, >= 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [1:0]                        enq_count,
  input  logic [mop_queue_pkg::MOP_W-1:0]   enq_mop0,
  input  logic [mop_queue_pkg::MOP_W-1:0]   enq_mop1,
  output logic                              enq_ready,
  output logic [$clog2(DEPTH):0]            free_slots,
  output logic                              deq_valid,
  output logic [mop_queue_pkg::MOP_W-1:0]   deq_mop,
  input  logic                              deq_ready,
  output logic [$clog2(DEPTH):0]            occupancy
);
  import mop_queue_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_PARTIAL  = 2'd1,
    S_NEARFULL = 2'd2,
    S_FULL     = 2'd3
  } state_t;

  logic [MOP_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tail_p1;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] occ_nx;
  logic [CNT_W-1:0] free_q;
  logic [1:0]       enq_eff;
  logic             enq_acc;
  logic             deq_fire;
  state_t           state;
  state_t           state_nx;

  // Admission and dequeue decisions, based only on start-of-cycle occupancy.
  always_comb begin
    enq_eff  = (enq_count == 2'd3) ? 2'd0 : enq_count;
    enq_acc  = (enq_eff != 2'd0) && (CNT_W'(enq_eff) <= free_q) && !flush;
    deq_fire = deq_valid && deq_ready && !flush;
    tail_p1  = tail + 1'b1;
    if (reset || flush) begin
      occ_nx = '0;
    end else begin
      occ_nx = occ + (enq_acc ? CNT_W'(enq_eff) : CNT_W'(0))
                   - (deq_fire ? CNT_W'(1) : CNT_W'(0));
    end
  end

  // Pointer, occupancy and free-slot registers; flush rewinds everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      occ    <= '0;
      free_q <= CNT_W'(DEPTH);
    end else begin
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (deq_fire) head <= head + 1'b1;
        if (enq_acc)  tail <= tail + PTR_W'(enq_eff);
      end
      occ    <= occ_nx;
      free_q <= CNT_W'(DEPTH) - occ_nx;
    end
  end

  // Storage writes; contents are left alone on reset since they are masked at the output.
  always_ff @(posedge clk) begin
    if (enq_acc && !reset) begin
      mem[tail] <= enq_mop0;
      if (enq_eff == 2'd2) mem[tail_p1] <= enq_mop1;
    end
  end

  // Fill-level state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_nx;
  end

  // Fill-level state is derived from the occupancy that will hold next cycle.
  always_comb begin
    state_nx = S_PARTIAL;
    if (occ_nx == '0)                          state_nx = S_EMPTY;
    else if (occ_nx == CNT_W'(DEPTH))          state_nx = S_FULL;
    else if (occ_nx == CNT_W'(DEPTH - 1))      state_nx = S_NEARFULL;
  end

  // Head is read straight out of storage; an empty queue shows all zeros.
  always_comb begin
    deq_valid  = (occ != '0);
    deq_mop    = deq_valid ? mem[head] : '0;
    enq_ready  = (state == S_EMPTY) || (state == S_PARTIAL);
    occupancy  = occ;
    free_slots = free_q;
  end

endmodule
`default_nettype wire
